// File: rtl/phy_reset_seq.sv
// PHY power-up/restart sequencer: holds phy_resetn low, waits a settle time, then releases sys_rst.
// Optional status LED blink is built when PHY_RST_STATUS_LED_EN is defined.
module phy_reset_seq #(
  parameter int RESET_CYCLES  = 250000,
  parameter int SETTLE_CYCLES = 125000,
  parameter int CNT_W         = 20
`ifdef PHY_RST_STATUS_LED_EN
  , parameter int BLINK_BIT   = 22
`endif
) (
  input  logic osc25m,
  input  logic rst,
  input  logic restart,
  output logic phy_resetn,
  output logic sys_rst,
  output logic phy_ready,
  output logic led
);

  typedef enum logic [1:0] {
    HOLD   = 2'd0,
    SETTLE = 2'd1,
    RUN    = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] RESET_LAST  = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             phy_resetn_nxt, sys_rst_nxt, phy_ready_nxt;

  // Outputs are decoded from the next state so a restart shows after the very edge that samples it.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (restart) begin
      state_nxt = HOLD;
      cnt_nxt   = '0;
    end else begin
      case (state)
        HOLD: begin
          if (cnt == RESET_LAST) begin
            state_nxt = SETTLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            state_nxt = RUN;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        RUN: begin
          cnt_nxt = '0;
        end
        default: begin
          state_nxt = HOLD;
          cnt_nxt   = '0;
        end
      endcase
    end
    phy_resetn_nxt = (state_nxt != HOLD);
    sys_rst_nxt    = (state_nxt != RUN);
    phy_ready_nxt  = (state_nxt == RUN);
  end

  always_ff @(posedge osc25m) begin
    if (rst) begin
      state      <= HOLD;
      cnt        <= '0;
      phy_resetn <= 1'b0;
      sys_rst    <= 1'b1;
      phy_ready  <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      phy_resetn <= phy_resetn_nxt;
      sys_rst    <= sys_rst_nxt;
      phy_ready  <= phy_ready_nxt;
    end
  end

`ifdef PHY_RST_STATUS_LED_EN
  // Blink counter survives restart so the LED rhythm stays continuous across re-sequencing.
  logic [22:0] blink;

  always_ff @(posedge osc25m) begin
    if (rst) begin
      blink <= '0;
      led   <= 1'b1;
    end else begin
      blink <= blink + 23'd1;
      led   <= (state == RUN) ? 1'b0 : ~blink[BLINK_BIT];
    end
  end
`else
  assign led = 1'b1;
`endif

endmodule

// File: tb/tb_phy_reset_seq.sv
// Scoreboard bench for phy_reset_seq: a stimulus process pushes expected outputs computed from
// "edges since release" arithmetic; a monitor pops and compares one entry per clock.
module tb_phy_reset_seq;

  localparam int R  = 8;
  localparam int S  = 4;
  localparam int BB = 2;

  logic osc25m = 1'b0;
  logic rst = 1'b1;
  logic restart = 1'b0;
  logic phy_resetn, sys_rst, phy_ready, led;

  typedef struct {
    bit resetn;
    bit srst;
    bit ready;
    bit led;
    int cyc;
  } exp_t;

  exp_t q[$];

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // Reference model state: edges since the last rst/restart, and the free-running blink count.
  int          since_rel = 0;
  int unsigned blink_cnt = 0;
  bit          prev_ready = 1'b0;

  always #5 osc25m = ~osc25m;

  phy_reset_seq #(
    .RESET_CYCLES (R),
    .SETTLE_CYCLES(S),
    .CNT_W        (4)
`ifdef PHY_RST_STATUS_LED_EN
    , .BLINK_BIT  (BB)
`endif
  ) dut (
    .osc25m    (osc25m),
    .rst       (rst),
    .restart   (restart),
    .phy_resetn(phy_resetn),
    .sys_rst   (sys_rst),
    .phy_ready (phy_ready),
    .led       (led)
  );

  // Drive one cycle of inputs and queue the outputs expected after the next rising edge.
  task automatic applyStimulus(input bit r, input bit rs);
    exp_t e;
    @(negedge osc25m);
    rst = r;
    restart = rs;
    if (r) begin
      since_rel = 0;
      blink_cnt = 0;
      e.led = 1'b1;
    end else begin
`ifdef PHY_RST_STATUS_LED_EN
      e.led = prev_ready ? 1'b0 : ~(((blink_cnt & 32'h7F_FFFF) >> BB) & 1);
`else
      e.led = 1'b1;
`endif
      blink_cnt = blink_cnt + 1;
      if (rs) since_rel = 0;
      else if (since_rel < R + S) since_rel = since_rel + 1;
    end
    e.resetn = (since_rel >= R);
    e.ready  = (since_rel >= R + S);
    e.srst   = ~e.ready;
    e.cyc    = cyc;
    prev_ready = e.ready;
    cyc++;
    q.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    total++;
    if (phy_resetn !== e.resetn) begin
      bad++;
      $display("[TB] FAIL phy_resetn cyc=%0d got=%b exp=%b", e.cyc, phy_resetn, e.resetn);
    end
    total++;
    if (sys_rst !== e.srst) begin
      bad++;
      $display("[TB] FAIL sys_rst cyc=%0d got=%b exp=%b", e.cyc, sys_rst, e.srst);
    end
    total++;
    if (phy_ready !== e.ready) begin
      bad++;
      $display("[TB] FAIL phy_ready cyc=%0d got=%b exp=%b", e.cyc, phy_ready, e.ready);
    end
    total++;
    if (led !== e.led) begin
      bad++;
      $display("[TB] FAIL led cyc=%0d got=%b exp=%b", e.cyc, led, e.led);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge osc25m);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin : stimulus
    int guard;
    $display("[TB] reset release");
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < 17; i++) applyStimulus(1'b0, 1'b0);

    $display("[TB] restart in RUN");
    applyStimulus(1'b0, 1'b1);
    for (int i = 0; i < 15; i++) applyStimulus(1'b0, 1'b0);

    $display("[TB] restart in SETTLE");
    applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1);
    for (int i = 0; i < 14; i++) applyStimulus(1'b0, 1'b0);

    $display("[TB] held restart and reset priority");
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b1);
    for (int i = 0; i < 15; i++) applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1);
    for (int i = 0; i < 15; i++) applyStimulus(1'b0, 1'b0);

    $display("[TB] mid-HOLD reset");
    applyStimulus(1'b0, 1'b1);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < 16; i++) applyStimulus(1'b0, 1'b0);

    $display("[TB] random traffic");
    for (int i = 0; i < 1500; i++) begin
      applyStimulus(($urandom_range(0, 63) == 0), ($urandom_range(0, 31) == 0));
    end
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b0);

    guard = 0;
    while (q.size() > 0 && guard < 10) begin
      @(posedge osc25m);
      guard++;
    end
    #2;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("[TB] FAIL drain pending=%0d exp=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
